// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap controller.
// State encoding, cause codes, mstatus bit positions and privilege levels.
package trap_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTER,
    S_RETURN,
    S_REDIR
  } state_e;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_EXC,
    SEL_IRQ,
    SEL_RET,
    SEL_ILL
  } sel_e;

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_MSI     = 4'd3;
  localparam logic [3:0] CAUSE_MTI     = 4'd7;
  localparam logic [3:0] CAUSE_MEI     = 4'd11;

  localparam int MS_MIE    = 3;
  localparam int MS_MPIE   = 7;
  localparam int MS_MPP_LO = 11;
  localparam int MS_MPP_HI = 12;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

endpackage

// File: rtl/trap_controller_if.sv
// Bundle between the trap controller and its CSR file / fetch neighbours.
// slave is the controller side, master the environment side.
interface trap_controller_if #(
  parameter int XLEN = 64
);
  logic            boundary;
  logic            exc_req;
  logic [3:0]      exc_code;
  logic [XLEN-1:0] exc_val;
  logic [XLEN-1:0] exc_pc;
  logic            mret_req;
  logic [XLEN-1:0] mip_in;
  logic [XLEN-1:0] mie_in;
  logic [XLEN-1:0] mstatus_in;
  logic [XLEN-1:0] mtvec_in;
  logic [XLEN-1:0] mepc_in;
  logic            redirect_ready;
  logic            trap_taken;
  logic            trap_done;
  logic [XLEN-1:0] mepc_next;
  logic [XLEN-1:0] mcause_next;
  logic [XLEN-1:0] mtval_next;
  logic [XLEN-1:0] mstatus_next;
  logic [1:0]      priv_lvl;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            stall;

  modport slave (
    input  boundary, exc_req, exc_code, exc_val, exc_pc, mret_req,
    input  mip_in, mie_in, mstatus_in, mtvec_in, mepc_in,
    input  redirect_ready,
    output trap_taken, trap_done,
    output mepc_next, mcause_next, mtval_next, mstatus_next,
    output priv_lvl, redirect_valid, redirect_pc, stall
  );

  modport master (
    output boundary, exc_req, exc_code, exc_val, exc_pc, mret_req,
    output mip_in, mie_in, mstatus_in, mtvec_in, mepc_in,
    output redirect_ready,
    input  trap_taken, trap_done,
    input  mepc_next, mcause_next, mtval_next, mstatus_next,
    input  priv_lvl, redirect_valid, redirect_pc, stall
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Machine interrupt priority encoder: MEI > MSI > MTI.
// Only the three machine-level sources produce a valid code.
module irq_prio_enc
  import trap_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] pend_i,
  output logic            valid_o,
  output logic [3:0]      code_o
);

  logic unused_pend;
  assign unused_pend = ^{pend_i[XLEN-1:12], pend_i[10:8],
                         pend_i[6:4], pend_i[2:0]};

  always_comb begin
    valid_o = 1'b1;
    code_o  = CAUSE_MEI;
    priority case (1'b1)
      pend_i[11]: code_o = CAUSE_MEI;
      pend_i[3]:  code_o = CAUSE_MSI;
      pend_i[7]:  code_o = CAUSE_MTI;
      default: begin
        valid_o = 1'b0;
        code_o  = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap entry / MRET sequencer with privilege and redirect.
// TRAP_VECTORED_EN: vectored mtvec mode for interrupts.
module trap_controller
  import trap_pkg::*;
#(
  parameter int         XLEN       = 64,
  parameter logic [1:0] RESET_PRIV = PRIV_M
) (
  input logic              clk,
  input logic              rst,
  trap_controller_if.slave bus
);

  state_e          state_q;
  logic [1:0]      priv_q, npriv_q;
  logic            taken_q, done_q, rvalid_q;
  logic [XLEN-1:0] mepc_q, mcause_q, mtval_q, mstatus_q;
  logic [XLEN-1:0] rpc_q, tgt_q;

  logic            irq_vld, irq_en;
  logic [3:0]      irq_code;
  logic [XLEN-1:0] pend, base, irq_tgt;
  logic [XLEN-1:0] ms_trap, ms_ret;
  logic [XLEN-1:0] t_cause, t_val, t_tgt;
  sel_e            sel;

  assign pend = bus.mip_in & bus.mie_in;
  assign base = {bus.mtvec_in[XLEN-1:2], 2'b00};

  irq_prio_enc #(.XLEN(XLEN)) u_enc (
    .pend_i  (pend),
    .valid_o (irq_vld),
    .code_o  (irq_code)
  );

  assign irq_en = irq_vld &&
                  (priv_q != PRIV_M || bus.mstatus_in[MS_MIE]);

`ifdef TRAP_VECTORED_EN
  assign irq_tgt = (bus.mtvec_in[1:0] == 2'b01)
                 ? base + XLEN'({irq_code, 2'b00})
                 : base;
  logic unused_pc;
  assign unused_pc = ^bus.exc_pc[1:0];
`else
  assign irq_tgt = base;
  logic unused_lo;
  assign unused_lo = ^{bus.mtvec_in[1:0], bus.exc_pc[1:0]};
`endif

  always_comb begin
    sel = SEL_NONE;
    if (bus.boundary) begin
      priority case (1'b1)
        bus.exc_req: sel = SEL_EXC;
        irq_en:      sel = SEL_IRQ;
        bus.mret_req:
          sel = (priv_q == PRIV_M) ? SEL_RET : SEL_ILL;
        default:     sel = SEL_NONE;
      endcase
    end
  end

  always_comb begin
    ms_trap = bus.mstatus_in;
    ms_trap[MS_MPIE] = bus.mstatus_in[MS_MIE];
    ms_trap[MS_MIE]  = 1'b0;
    ms_trap[MS_MPP_HI:MS_MPP_LO] = priv_q;
    ms_ret = bus.mstatus_in;
    ms_ret[MS_MIE]  = bus.mstatus_in[MS_MPIE];
    ms_ret[MS_MPIE] = 1'b1;
    ms_ret[MS_MPP_HI:MS_MPP_LO] = PRIV_U;
  end

  always_comb begin
    t_cause = {{(XLEN-4){1'b0}}, bus.exc_code};
    t_val   = bus.exc_val;
    t_tgt   = base;
    unique case (sel)
      SEL_IRQ: begin
        t_cause = {1'b1, {(XLEN-5){1'b0}}, irq_code};
        t_val   = '0;
        t_tgt   = irq_tgt;
      end
      SEL_ILL: begin
        t_cause = {{(XLEN-4){1'b0}}, CAUSE_ILLEGAL};
        t_val   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      priv_q    <= RESET_PRIV;
      npriv_q   <= RESET_PRIV;
      taken_q   <= 1'b0;
      done_q    <= 1'b0;
      rvalid_q  <= 1'b0;
      mepc_q    <= '0;
      mcause_q  <= '0;
      mtval_q   <= '0;
      mstatus_q <= '0;
      rpc_q     <= '0;
      tgt_q     <= '0;
    end else begin
      taken_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          unique case (sel)
            SEL_EXC, SEL_IRQ, SEL_ILL: begin
              state_q   <= S_ENTER;
              taken_q   <= 1'b1;
              mepc_q    <= {bus.exc_pc[XLEN-1:2], 2'b00};
              mcause_q  <= t_cause;
              mtval_q   <= t_val;
              mstatus_q <= ms_trap;
              tgt_q     <= t_tgt;
            end
            SEL_RET: begin
              state_q   <= S_RETURN;
              done_q    <= 1'b1;
              mepc_q    <= bus.mepc_in;
              mstatus_q <= ms_ret;
              tgt_q     <= bus.mepc_in;
              npriv_q   <= bus.mstatus_in[MS_MPP_HI:MS_MPP_LO];
            end
            default: ;
          endcase
        end
        S_ENTER: begin
          priv_q   <= PRIV_M;
          rvalid_q <= 1'b1;
          rpc_q    <= tgt_q;
          state_q  <= S_REDIR;
        end
        S_RETURN: begin
          priv_q   <= npriv_q;
          rvalid_q <= 1'b1;
          rpc_q    <= tgt_q;
          state_q  <= S_REDIR;
        end
        S_REDIR: begin
          if (bus.redirect_ready) begin
            rvalid_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.trap_taken     = taken_q;
  assign bus.trap_done      = done_q;
  assign bus.mepc_next      = mepc_q;
  assign bus.mcause_next    = mcause_q;
  assign bus.mtval_next     = mtval_q;
  assign bus.mstatus_next   = mstatus_q;
  assign bus.priv_lvl       = priv_q;
  assign bus.redirect_valid = rvalid_q;
  assign bus.redirect_pc    = rpc_q;
  assign bus.stall          = (state_q != S_IDLE);

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller: expected trap/return records are
// queued at stimulus time and retired on trap pulses and redirect handshakes.
module tb_trap_controller;
  import trap_pkg::*;

  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trap_controller_if #(.XLEN(XLEN)) bus();

  trap_controller #(.XLEN(XLEN), .RESET_PRIV(2'b11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        done;
    logic [63:0] mcause;
    logic [63:0] mepc;
    logic [63:0] mtval;
    logic [63:0] mstatus;
    logic [63:0] tgt;
    logic [1:0]  priv;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [1:0]  priv_m = 2'b11;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] irq_model(input logic [63:0] p);
    if (p[11]) return 4'd11;
    if (p[3])  return 4'd3;
    return 4'd7;
  endfunction

  task automatic push_trap(input logic irq, input logic [3:0] code,
                           input logic [63:0] val);
    exp_t        e;
    logic [63:0] ms;
    ms = bus.mstatus_in;
    ms[7] = ms[3];
    ms[3] = 1'b0;
    ms[12:11] = priv_m;
    e.done    = 1'b0;
    e.mcause  = irq ? {1'b1, 59'b0, code} : {60'b0, code};
    e.mtval   = irq ? 64'd0 : val;
    e.mepc    = {bus.exc_pc[63:2], 2'b00};
    e.mstatus = ms;
    e.tgt     = {bus.mtvec_in[63:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    if (irq && bus.mtvec_in[1:0] == 2'b01)
      e.tgt = e.tgt + {58'b0, code, 2'b00};
`endif
    e.priv = 2'b11;
    priv_m = 2'b11;
    sb.push_back(e);
  endtask

  task automatic push_ret();
    exp_t        e;
    logic [63:0] ms;
    ms = bus.mstatus_in;
    ms[3] = bus.mstatus_in[7];
    ms[7] = 1'b1;
    ms[12:11] = 2'b00;
    e.done    = 1'b1;
    e.mcause  = '0;
    e.mtval   = '0;
    e.mepc    = bus.mepc_in;
    e.mstatus = ms;
    e.tgt     = bus.mepc_in;
    e.priv    = bus.mstatus_in[12:11];
    priv_m    = bus.mstatus_in[12:11];
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("pulse_excl", bus.trap_taken & bus.trap_done, 0);
      if (bus.trap_taken || bus.trap_done) begin
        if (sb.size() == 0) begin
          chk("unexp_pulse", 1, 0);
        end else begin
          chk("kind_done", bus.trap_done, sb[0].done);
          chk("mstatus_next", bus.mstatus_next, sb[0].mstatus);
          chk("mepc_next", bus.mepc_next, sb[0].mepc);
          if (!sb[0].done) begin
            chk("mcause_next", bus.mcause_next, sb[0].mcause);
            chk("mtval_next", bus.mtval_next, sb[0].mtval);
          end
        end
      end
      if (bus.redirect_valid && bus.redirect_ready) begin
        if (sb.size() == 0) begin
          chk("unexp_redir", 1, 0);
        end else begin
          chk("redirect_pc", bus.redirect_pc, sb[0].tgt);
          chk("priv_lvl", {62'b0, bus.priv_lvl}, {62'b0, sb[0].priv});
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic fire(input logic evt);
    @(negedge clk);
    bus.boundary = 1'b1;
    @(posedge clk);
    #1;
    bus.boundary = 1'b0;
    bus.exc_req  = 1'b0;
    bus.mret_req = 1'b0;
    if (evt) begin
      chk("lat1_valid", bus.redirect_valid, 0);
      chk("lat1_stall", bus.stall, 1);
      @(posedge clk);
      #1;
      chk("lat2_valid", bus.redirect_valid, 1);
    end else begin
      chk("idle_stall", bus.stall, 0);
      @(posedge clk);
      #1;
      chk("idle_stall2", bus.stall, 0);
    end
  endtask

  task automatic wait_idle();
    int i = 0;
    while (bus.stall && i < 30) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("idle_timeout", bus.stall, 0);
  endtask

  task automatic set_exc(input logic [3:0] code, input logic [63:0] val,
                         input logic [63:0] pc);
    bus.exc_req  = 1'b1;
    bus.exc_code = code;
    bus.exc_val  = val;
    bus.exc_pc   = pc;
  endtask

  initial begin
    bus.boundary = 0; bus.exc_req = 0; bus.exc_code = 0;
    bus.exc_val = 0; bus.exc_pc = 0; bus.mret_req = 0;
    bus.mip_in = 0; bus.mie_in = 0; bus.mstatus_in = 0;
    bus.mtvec_in = 64'h800; bus.mepc_in = 0; bus.redirect_ready = 1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_priv", {62'b0, bus.priv_lvl}, 3);
    chk("rst_stall", bus.stall, 0);
    chk("rst_valid", bus.redirect_valid, 0);
    chk("rst_taken", bus.trap_taken, 0);
    chk("rst_mcause", bus.mcause_next, 0);
    @(negedge clk);
    rst = 1'b0;

    // illegal instruction exception from M-mode
    bus.mstatus_in = 64'h8;
    set_exc(4'd2, 64'hdead, 64'h100);
    push_trap(0, 4'd2, 64'hdead);
    fire(1);
    wait_idle();
    chk("exc_priv", {62'b0, bus.priv_lvl}, 3);

    // misaligned pc truncated into mepc
    set_exc(4'd5, 64'h1234, 64'h103);
    push_trap(0, 4'd5, 64'h1234);
    fire(1);
    wait_idle();

    // request without boundary is ignored
    set_exc(4'd2, 0, 64'h40);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("noboundary_stall", bus.stall, 0);
    end
    bus.exc_req = 1'b0;

    // MEI wins among MEI/MSI/MTI
    bus.mip_in = 64'h888; bus.mie_in = 64'h888;
    bus.mtvec_in = 64'h801; bus.exc_pc = 64'h204;
    push_trap(1, irq_model(64'h888), 0);
    fire(1);
    wait_idle();
    bus.mtvec_in = 64'h800;

    // M-mode with MIE=0: no interrupt
    bus.mstatus_in = 64'h0;
    bus.mip_in = 64'h80; bus.mie_in = 64'h80;
    fire(0);
    bus.mip_in = 0; bus.mie_in = 0;

    // exception beats MRET in the same cycle
    bus.mstatus_in = 64'h8;
    set_exc(4'd4, 64'h55, 64'h300);
    bus.mret_req = 1'b1;
    push_trap(0, 4'd4, 64'h55);
    fire(1);
    wait_idle();

    // MRET to U-mode
    bus.mstatus_in = 64'h80; bus.mepc_in = 64'h2000;
    bus.mret_req = 1'b1;
    push_ret();
    fire(1);
    wait_idle();
    chk("mret_priv", {62'b0, bus.priv_lvl}, 0);

    // U-mode interrupt taken even with MIE=0
    bus.mstatus_in = 64'h0;
    bus.mip_in = 64'h80; bus.mie_in = 64'h80; bus.exc_pc = 64'h2008;
    push_trap(1, irq_model(64'h80), 0);
    fire(1);
    wait_idle();
    bus.mip_in = 0; bus.mie_in = 0;

    // back to U, then MRET there is illegal
    bus.mstatus_in = 64'h80; bus.mepc_in = 64'h3000;
    bus.mret_req = 1'b1;
    push_ret();
    fire(1);
    wait_idle();
    bus.mstatus_in = 64'h8; bus.exc_pc = 64'h3000;
    bus.exc_val = 64'hffff;
    bus.mret_req = 1'b1;
    push_trap(0, 4'd2, 0);
    fire(1);
    wait_idle();

    // redirect held while fetch is not ready
    bus.redirect_ready = 1'b0;
    set_exc(4'd1, 64'h77, 64'h400);
    push_trap(0, 4'd1, 64'h77);
    fire(1);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("hold_valid", bus.redirect_valid, 1);
      chk("hold_pc", bus.redirect_pc, 64'h800);
      chk("hold_stall", bus.stall, 1);
    end
    bus.redirect_ready = 1'b1;
    wait_idle();

    // reset while in REDIRECT
    bus.redirect_ready = 1'b0;
    set_exc(4'd6, 64'h9, 64'h500);
    push_trap(0, 4'd6, 64'h9);
    fire(1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid_valid", bus.redirect_valid, 0);
    chk("rstmid_stall", bus.stall, 0);
    chk("rstmid_priv", {62'b0, bus.priv_lvl}, 3);
    chk("rstmid_pc", bus.redirect_pc, 0);
    chk("rstmid_ms", bus.mstatus_next, 0);
    sb.delete();
    priv_m = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    bus.redirect_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
